// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Integer architectural register file with a per-register
//               busy-bit scoreboard.
//               - NREGS registers of XLEN bits; register 0 always reads zero.
//               - Two combinational read ports and one synchronous write port.
//               - BYPASS=1 forwards same-cycle write data to the read ports.
//               - Busy bits let issue detect RAW hazards on in-flight
//                 destinations: set by bs_ena, cleared by a writeback to the
//                 same register, and cleared all at once by flush.
// Ports       : clk, rst             clock, synchronous active-high reset
//               w_addr/w_data/w_ena  write port (writeback)
//               r_addr1/2, r_ena1/2  read addresses and enables
//               r_data1/2            read data (combinational)
//               r_busy1/2            source has a pending producer (comb.)
//               bs_ena/bs_addr       mark a destination busy (issue)
//               flush                clear every busy bit
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(NREGS)-1:0]   w_addr,
    input  logic [XLEN-1:0]            w_data,
    input  logic                       w_ena,
    input  logic [$clog2(NREGS)-1:0]   r_addr1,
    input  logic [$clog2(NREGS)-1:0]   r_addr2,
    input  logic                       r_ena1,
    input  logic                       r_ena2,
    output logic [XLEN-1:0]            r_data1,
    output logic [XLEN-1:0]            r_data2,
    output logic                       r_busy1,
    output logic                       r_busy2,
    input  logic                       bs_ena,
    input  logic [$clog2(NREGS)-1:0]   bs_addr,
    input  logic                       flush
);

    localparam int c_AW = $clog2(NREGS);

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    // Register 0 is held at zero by the same block that owns the array, so
    // a write to address 0 simply has no effect.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst || (i == 0)) begin
                r_regs[i] <= '0;
            end else if (w_ena && (w_addr == i[c_AW-1:0])) begin
                r_regs[i] <= w_data;
            end
        end
    end

    // Busy priority: flush > set by a newly issued producer > clear by
    // writeback. A set beats a same-cycle clear of the same register because
    // the writeback belongs to the older producer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst || flush || (i == 0)) begin
                r_busy[i] <= 1'b0;
            end else if (bs_ena && (bs_addr == i[c_AW-1:0])) begin
                r_busy[i] <= 1'b1;
            end else if (w_ena && (w_addr == i[c_AW-1:0])) begin
                r_busy[i] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    logic [c_AW-1:0] w_raddr [2];
    logic            w_rena  [2];

    assign w_raddr[0] = r_addr1;
    assign w_raddr[1] = r_addr2;
    assign w_rena[0]  = r_ena1;
    assign w_rena[1]  = r_ena2;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rport
            logic            w_hit;
            logic [XLEN-1:0] w_rdata;
            logic            w_rbusy;

            // Forwarding hit: the register being read is written this cycle.
            // The value is therefore available now, so it is not reported busy.
            assign w_hit = (BYPASS != 0) && w_ena && (w_addr == w_raddr[p]);

            always_comb begin
                w_rdata = '0;
                w_rbusy = 1'b0;
                if (!rst && w_rena[p] && (w_raddr[p] != '0)) begin
                    if (w_hit) begin
                        w_rdata = w_data;
                    end else begin
                        w_rdata = r_regs[w_raddr[p]];
                        w_rbusy = r_busy[w_raddr[p]];
                    end
                end
            end
        end
    endgenerate

    assign r_data1 = g_rport[0].w_rdata;
    assign r_data2 = g_rport[1].w_rdata;
    assign r_busy1 = g_rport[0].w_rbusy;
    assign r_busy2 = g_rport[1].w_rbusy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Scoreboard bench for regfile_sb. Two instances share all
//               inputs: one with BYPASS=1, one with BYPASS=0. The stimulus
//               process drives one cycle of inputs and queues the expected
//               outputs for that cycle; the monitor drains the queue on the
//               falling edge and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    // Output selectors for the scoreboard entries.
    localparam int S_D1B = 0;  // r_data1, BYPASS=1
    localparam int S_D2B = 1;  // r_data2, BYPASS=1
    localparam int S_B1B = 2;  // r_busy1, BYPASS=1
    localparam int S_B2B = 3;  // r_busy2, BYPASS=1
    localparam int S_D1N = 4;  // r_data1, BYPASS=0
    localparam int S_D2N = 5;  // r_data2, BYPASS=0
    localparam int S_B1N = 6;  // r_busy1, BYPASS=0

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_ena;
    logic [AW-1:0]   r_addr1, r_addr2;
    logic            r_ena1, r_ena2;
    logic            bs_ena;
    logic [AW-1:0]   bs_addr;
    logic            flush;

    logic [XLEN-1:0] d1_b, d2_b, d1_n, d2_n;
    logic            b1_b, b2_b, b1_n, b2_n;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst),
        .w_addr(w_addr), .w_data(w_data), .w_ena(w_ena),
        .r_addr1(r_addr1), .r_addr2(r_addr2), .r_ena1(r_ena1), .r_ena2(r_ena2),
        .r_data1(d1_b), .r_data2(d2_b), .r_busy1(b1_b), .r_busy2(b2_b),
        .bs_ena(bs_ena), .bs_addr(bs_addr), .flush(flush)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst),
        .w_addr(w_addr), .w_data(w_data), .w_ena(w_ena),
        .r_addr1(r_addr1), .r_addr2(r_addr2), .r_ena1(r_ena1), .r_ena2(r_ena2),
        .r_data1(d1_n), .r_data2(d2_n), .r_busy1(b1_n), .r_busy2(b2_n),
        .bs_ena(bs_ena), .bs_addr(bs_addr), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        int              sel;
        logic [XLEN-1:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    function automatic logic [XLEN-1:0] sample(input int sel);
        case (sel)
            S_D1B:   return d1_b;
            S_D2B:   return d2_b;
            S_B1B:   return {63'd0, b1_b};
            S_B2B:   return {63'd0, b2_b};
            S_D1N:   return d1_n;
            S_D2N:   return d2_n;
            S_B1N:   return {63'd0, b1_n};
            default: return {63'd0, b2_n};
        endcase
    endfunction

    task automatic expect_out(input string name, input int sel, input logic [XLEN-1:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    // Monitor: every falling edge, compare whatever the stimulus queued.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [XLEN-1:0] act;
            e   = exp_q.pop_front();
            act = sample(e.sel);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%016h expected 0x%016h", e.name, act, e.exp);
            end
        end
    end

    task automatic idle();
        rst = 1'b0; w_ena = 1'b0; w_addr = '0; w_data = '0;
        r_ena1 = 1'b0; r_ena2 = 1'b0; r_addr1 = '0; r_addr2 = '0;
        bs_ena = 1'b0; bs_addr = '0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();

        // ---- Reset ----------------------------------------------------------
        idle();
        r_ena1 = 1'b1; r_addr1 = 5'd5;
        expect_out("post_reset_x5", S_D1B, 64'd0);
        expect_out("post_reset_busy", S_B1B, 64'd0);
        tick();

        for (int i = 1; i < NREGS; i++) begin
            idle();
            w_ena = 1'b1; w_addr = AW'(i); w_data = 64'h0101_0101_0101_0101 * i;
            bs_ena = (i == 12); bs_addr = 5'd12;
            tick();
        end

        idle();
        r_ena1 = 1'b1; r_addr1 = 5'd5; r_ena2 = 1'b1; r_addr2 = 5'd12;
        expect_out("loaded_x5", S_D1B, 64'h0505_0505_0505_0505);
        expect_out("loaded_busy_x12", S_B2B, 64'd1);
        tick();

        // Reset cycle: outputs forced to zero, pending write and busy-set lost.
        idle();
        rst = 1'b1;
        r_ena1 = 1'b1; r_addr1 = 5'd5; r_ena2 = 1'b1; r_addr2 = 5'd12;
        w_ena = 1'b1; w_addr = 5'd20; w_data = 64'hDEAD;
        bs_ena = 1'b1; bs_addr = 5'd21;
        expect_out("in_reset_d1", S_D1B, 64'd0);
        expect_out("in_reset_busy2", S_B2B, 64'd0);
        tick();

        for (int i = 0; i < NREGS; i += 2) begin
            idle();
            r_ena1 = 1'b1; r_addr1 = AW'(i); r_ena2 = 1'b1; r_addr2 = AW'(i + 1);
            expect_out($sformatf("cleared_x%0d", i), S_D1N, 64'd0);
            expect_out($sformatf("cleared_x%0d", i + 1), S_D2N, 64'd0);
            expect_out($sformatf("cleared_busy_x%0d", i), S_B1B, 64'd0);
            expect_out($sformatf("cleared_busy_x%0d", i + 1), S_B2B, 64'd0);
            tick();
        end

        // ---- Write to x0 is discarded ---------------------------------------
        idle();
        w_ena = 1'b1; w_addr = 5'd0; w_data = 64'hFFFF_FFFF_FFFF_FFFF;
        r_ena1 = 1'b1; r_addr1 = 5'd0;
        expect_out("x0_no_bypass", S_D1B, 64'd0);
        tick();
        idle();
        r_ena1 = 1'b1; r_addr1 = 5'd0;
        expect_out("x0_after_write", S_D1B, 64'd0);
        tick();

        // ---- Write / read ---------------------------------------------------
        idle();
        w_ena = 1'b1; w_addr = 5'd5; w_data = 64'h1234_5678_9ABC_DEF0;
        tick();
        idle();
        r_ena1 = 1'b1; r_addr1 = 5'd5;
        expect_out("read_x5_byp", S_D1B, 64'h1234_5678_9ABC_DEF0);
        expect_out("read_x5_nob", S_D1N, 64'h1234_5678_9ABC_DEF0);
        tick();
        idle();
        r_ena1 = 1'b0; r_addr1 = 5'd5;
        expect_out("read_x5_disabled", S_D1B, 64'd0);
        tick();

        // ---- Bypass ---------------------------------------------------------
        idle();
        w_ena = 1'b1; w_addr = 5'd7; w_data = 64'h11;
        tick();
        idle();
        w_ena = 1'b1; w_addr = 5'd7; w_data = 64'hAA;
        r_ena2 = 1'b1; r_addr2 = 5'd7;
        expect_out("bypass_x7_byp", S_D2B, 64'hAA);
        expect_out("bypass_x7_nob", S_D2N, 64'h11);
        tick();
        idle();
        r_ena2 = 1'b1; r_addr2 = 5'd7;
        expect_out("stored_x7_nob", S_D2N, 64'hAA);
        tick();

        // ---- Scoreboard set / clear -----------------------------------------
        idle();
        bs_ena = 1'b1; bs_addr = 5'd3;
        r_ena1 = 1'b1; r_addr1 = 5'd3;
        expect_out("busy_x3_same_cycle", S_B1B, 64'd0);
        tick();
        idle();
        r_ena1 = 1'b1; r_addr1 = 5'd3;
        expect_out("busy_x3_set", S_B1B, 64'd1);
        expect_out("busy_x3_set_nob", S_B1N, 64'd1);
        tick();
        idle();
        w_ena = 1'b1; w_addr = 5'd3; w_data = 64'h33;
        r_ena1 = 1'b1; r_addr1 = 5'd3;
        expect_out("busy_x3_wb_byp", S_B1B, 64'd0);
        expect_out("busy_x3_wb_nob", S_B1N, 64'd1);
        expect_out("data_x3_wb_nob", S_D1N, 64'd0);
        tick();
        idle();
        r_ena1 = 1'b1; r_addr1 = 5'd3;
        expect_out("busy_x3_after", S_B1B, 64'd0);
        expect_out("busy_x3_after_nob", S_B1N, 64'd0);
        expect_out("data_x3_after", S_D1B, 64'h33);
        tick();

        // ---- Set beats clear ------------------------------------------------
        idle();
        bs_ena = 1'b1; bs_addr = 5'd9;
        w_ena = 1'b1; w_addr = 5'd9; w_data = 64'h99;
        tick();
        idle();
        r_ena1 = 1'b1; r_addr1 = 5'd9; r_ena2 = 1'b0; r_addr2 = 5'd9;
        expect_out("set_wins_busy_x9", S_B1B, 64'd1);
        expect_out("set_wins_data_x9", S_D1B, 64'h99);
        expect_out("busy_x9_disabled", S_B2B, 64'd0);
        tick();

        // ---- Flush ----------------------------------------------------------
        for (int i = 2; i <= 6; i += 2) begin
            idle();
            bs_ena = 1'b1; bs_addr = AW'(i);
            tick();
        end
        idle();
        flush = 1'b1; bs_ena = 1'b1; bs_addr = 5'd8;
        w_ena = 1'b1; w_addr = 5'd10; w_data = 64'h55;
        r_ena1 = 1'b1; r_addr1 = 5'd6; r_ena2 = 1'b1; r_addr2 = 5'd2;
        expect_out("flush_cycle_busy_x6", S_B1B, 64'd1);
        expect_out("flush_cycle_busy_x2", S_B2B, 64'd1);
        tick();
        idle();
        r_ena1 = 1'b1; r_addr1 = 5'd2; r_ena2 = 1'b1; r_addr2 = 5'd4;
        expect_out("flushed_busy_x2", S_B1B, 64'd0);
        expect_out("flushed_busy_x4", S_B2B, 64'd0);
        tick();
        idle();
        r_ena1 = 1'b1; r_addr1 = 5'd6; r_ena2 = 1'b1; r_addr2 = 5'd8;
        expect_out("flushed_busy_x6", S_B1B, 64'd0);
        expect_out("flushed_busy_x8", S_B2B, 64'd0);
        tick();
        idle();
        r_ena1 = 1'b1; r_addr1 = 5'd10; r_ena2 = 1'b1; r_addr2 = 5'd9;
        expect_out("flush_write_x10", S_D1N, 64'h55);
        expect_out("flushed_busy_x9", S_B2B, 64'd0);
        tick();

        idle();
        tick();
        stim_done = 1'b1;
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
